// File: rtl/sr_arb_pkg.sv
// Shared definitions for the round-robin set/reset flag arbiter.
// Holds op encodings, the requester-count bound and the index-width helper.
package sr_arb_pkg;

    localparam logic OP_CLR  = 1'b0;
    localparam logic OP_SET  = 1'b1;
    localparam int   MAX_REQ = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr.sv
// Set/reset flip-flop with synchronous active-low reset.
// Reset and R dominate S, so the output is defined even for S=R=1.
module sr (
    input  logic clk,
    input  logic n_rst,
    input  logic R,
    input  logic S,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (!n_rst)
            Q <= 1'b0;
        else if (R)
            Q <= 1'b0;
        else if (S)
            Q <= 1'b1;
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter turning granted set/clear commands into registered S/R pulses.
// Define SR_ARB_LOCK_EN to make the flag a mutex with owner tracking and reject pulses.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               sr_s,
    output logic               sr_r,
    output logic               flag,
    output logic               err,
    output logic [IDW-1:0]     owner_id,
    output logic               owner_valid
);

    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;
    logic           found;
    logic           hs;
    logic           win_op;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt      = '0;
        gnt_id   = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_sum >= NUM_REQ_W)
                cand_sum = cand_sum - NUM_REQ_W;
            cand = cand_sum[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_id    = cand;
            end
        end
        if (!n_rst) begin
            gnt    = '0;
            gnt_id = '0;
        end
    end

    // gnt is already qualified by req_valid, so any grant bit is a handshake.
    assign hs     = |gnt;
    assign win_op = req_op[gnt_id];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst)
            ptr <= '0;
        else if (hs)
            ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
    end

`ifdef SR_ARB_LOCK_EN
    // Ownership follows the handshake rather than flag, so back-to-back sets resolve correctly.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr_s        <= 1'b0;
            sr_r        <= 1'b0;
            err         <= 1'b0;
            owner_valid <= 1'b0;
            owner_id    <= '0;
        end else begin
            sr_s <= 1'b0;
            sr_r <= 1'b0;
            err  <= 1'b0;
            if (hs) begin
                if (win_op == OP_SET) begin
                    if (!owner_valid) begin
                        sr_s        <= 1'b1;
                        owner_valid <= 1'b1;
                        owner_id    <= gnt_id;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (owner_valid && owner_id == gnt_id) begin
                    sr_r        <= 1'b1;
                    owner_valid <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr_s <= 1'b0;
            sr_r <= 1'b0;
        end else begin
            sr_s <= hs && (win_op == OP_SET);
            sr_r <= hs && (win_op == OP_CLR);
        end
    end

    assign err         = 1'b0;
    assign owner_valid = 1'b0;
    assign owner_id    = '0;
`endif

    sr u_sr (
        .clk   (clk),
        .n_rst (n_rst),
        .R     (sr_r),
        .S     (sr_s),
        .Q     (flag)
    );

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: a cycle model pushes expected pulses to a queue,
// popped and compared one cycle later; explicit checks cover the directed scenarios.
module tb_sr_flag_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    typedef struct packed {
        logic s;
        logic r;
        logic e;
    } pulse_t;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_id;
    logic               sr_s;
    logic               sr_r;
    logic               flag;
    logic               err;
    logic [IDW-1:0]     owner_id;
    logic               owner_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state; X until the first reset edge, matching the DUT.
    int       m_ptr = 0;
    logic     m_flag = 1'bx;
    logic     m_ov = 1'bx;
    logic [IDW-1:0] m_oid = 'x;
    pulse_t   exp_q[$];

    logic [NUM_REQ-1:0] last_gnt;
    logic [IDW-1:0]     last_gnt_id;
    logic               last_sr_s;
    logic               last_sr_r;
    logic               last_flag;
    logic               last_err;
    logic               last_ov;
    logic [IDW-1:0]     last_oid;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .sr_s        (sr_s),
        .sr_r        (sr_r),
        .flag        (flag),
        .err         (err),
        .owner_id    (owner_id),
        .owner_valid (owner_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive just after a rising edge, check mid-cycle, advance the model at the edge.
    task automatic cycle(input logic rst_v, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] op);
        logic [NUM_REQ-1:0] e_gnt;
        int                 e_id;
        logic               hit;
        pulse_t             cur;
        pulse_t             nxt;
        n_rst     = rst_v;
        req_valid = v;
        req_op    = op;
        #4;
        e_gnt = '0;
        e_id  = 0;
        hit   = 1'b0;
        if (rst_v) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (!hit && v[i]) begin
                    hit      = 1'b1;
                    e_id     = i;
                    e_gnt[i] = 1'b1;
                end
            end
        end
        last_gnt    = gnt;
        last_gnt_id = gnt_id;
        last_sr_s   = sr_s;
        last_sr_r   = sr_r;
        last_flag   = flag;
        last_err    = err;
        last_ov     = owner_valid;
        last_oid    = owner_id;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("gnt_id", 32'(gnt_id), 32'(e_id));
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        cur = '0;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("sr_s", 32'(sr_s), 32'(cur.s));
            check("sr_r", 32'(sr_r), 32'(cur.r));
            check("err", 32'(err), 32'(cur.e));
        end
        check("flag", 32'(flag), 32'(m_flag));
`ifdef SR_ARB_LOCK_EN
        check("owner_valid", 32'(owner_valid), 32'(m_ov));
        if (m_ov === 1'b1)
            check("owner_id", 32'(owner_id), 32'(m_oid));
`else
        check("owner_valid_tied", 32'(owner_valid), 32'd0);
        check("owner_id_tied", 32'(owner_id), 32'd0);
`endif
        @(posedge clk);
        #1;
        nxt = '0;
        if (!rst_v) begin
            m_ptr  = 0;
            m_flag = 1'b0;
            m_ov   = 1'b0;
            m_oid  = '0;
            exp_q.delete();
        end else begin
            if (cur.s)
                m_flag = 1'b1;
            else if (cur.r)
                m_flag = 1'b0;
            if (hit) begin
                m_ptr = (e_id + 1) % NUM_REQ;
`ifdef SR_ARB_LOCK_EN
                if (op[e_id]) begin
                    if (m_ov === 1'b0) begin
                        nxt.s = 1'b1;
                        m_ov  = 1'b1;
                        m_oid = IDW'(e_id);
                    end else begin
                        nxt.e = 1'b1;
                    end
                end else if (m_ov === 1'b1 && m_oid == IDW'(e_id)) begin
                    nxt.r = 1'b1;
                    m_ov  = 1'b0;
                end else begin
                    nxt.e = 1'b1;
                end
`else
                nxt.s = op[e_id];
                nxt.r = !op[e_id];
`endif
            end
        end
        exp_q.push_back(nxt);
    endtask

    initial begin
        n_rst     = 1'b0;
        req_valid = '0;
        req_op    = '0;

        // Reset held with all requesters valid: no grant, no pulse.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'b1111, 4'b0000);
            check("rst_gnt", 32'(last_gnt), 32'd0);
        end

        // Rotation from reset release: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 4'b1111, 4'b0000);
            check("rot_id", 32'(last_gnt_id), 32'(k % 4));
            check("rot_bits", 32'($countones(last_gnt)), 32'd1);
        end

        // Pointer skip: move ptr to 1, then 1001 grants 3, 0, 3.
        cycle(1'b1, 4'b0001, 4'b0000);
        cycle(1'b1, 4'b1001, 4'b0000);
        check("skip_a", 32'(last_gnt_id), 32'd3);
        cycle(1'b1, 4'b1001, 4'b0000);
        check("skip_b", 32'(last_gnt_id), 32'd0);
        cycle(1'b1, 4'b1001, 4'b0000);
        check("skip_c", 32'(last_gnt_id), 32'd3);

        // Requester 2 sets, then clears.
        cycle(1'b1, 4'b0100, 4'b0100);
        check("set_gnt", 32'(last_gnt), 32'b0100);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("set_pulse", 32'(last_sr_s), 32'd1);
        check("set_flag_lat", 32'(last_flag), 32'd0);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("set_flag", 32'(last_flag), 32'd1);
        cycle(1'b1, 4'b0100, 4'b0000);
        check("clr_gnt", 32'(last_gnt), 32'b0100);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("clr_pulse", 32'(last_sr_r), 32'd1);
        check("clr_flag_lat", 32'(last_flag), 32'd1);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("clr_flag", 32'(last_flag), 32'd0);

`ifdef SR_ARB_LOCK_EN
        // Mutex: req 1 takes the flag, req 3's set and clear are rejected, req 1 releases.
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b1, 4'b1000, 4'b1000);
        check("lk_s1", 32'(last_sr_s), 32'd1);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("lk_err_set", 32'(last_err), 32'd1);
        check("lk_no_s2", 32'(last_sr_s), 32'd0);
        check("lk_flag", 32'(last_flag), 32'd1);
        check("lk_owner", 32'(last_oid), 32'd1);
        cycle(1'b1, 4'b1000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("lk_err_clr", 32'(last_err), 32'd1);
        check("lk_no_r", 32'(last_sr_r), 32'd0);
        cycle(1'b1, 4'b0010, 4'b0000);
        check("lk_flag_hold", 32'(last_flag), 32'd1);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("lk_r", 32'(last_sr_r), 32'd1);
        check("lk_ok", 32'(last_err), 32'd0);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("lk_flag_clr", 32'(last_flag), 32'd0);
        check("lk_unowned", 32'(last_ov), 32'd0);
`endif

        // Reset in the cycle the set pulse is high: pulse dropped, ptr back to 0.
        cycle(1'b1, 4'b0001, 4'b0001);
        cycle(1'b0, 4'b0000, 4'b0000);
        check("mid_pulse", 32'(last_sr_s), 32'd1);
        cycle(1'b1, 4'b1111, 4'b0000);
        check("mid_flag", 32'(last_flag), 32'd0);
        check("mid_ptr", 32'(last_gnt_id), 32'd0);
        check("mid_ov", 32'(last_ov), 32'd0);
        cycle(1'b1, 4'b0000, 4'b0000);
        check("mid_flag2", 32'(last_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
